// File: rtl/issue_pkg.sv
// Shared widths, functional-unit codes and the completion-entry type for the issue scoreboard.
package issue_pkg;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    localparam int NUM_REGS = 32;
    localparam int NUM_FU   = 3;
    localparam int MAX_LAT  = 8;

    localparam int REG_AW = clog2_f(NUM_REGS);
    localparam int FU_W   = clog2_f(NUM_FU);
    localparam int LAT_W  = clog2_f(MAX_LAT + 1);

    typedef enum logic [FU_W-1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_MEM = 2'd2
    } fu_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] regdest;
        logic              writereg;
    } wb_entry_t;

    // Latency 0 still takes one cycle; anything beyond the queue depth saturates.
    function automatic logic [LAT_W-1:0] eff_latency(input logic [LAT_W-1:0] lat);
        if (lat == '0) return LAT_W'(1);
        if (lat > LAT_W'(MAX_LAT)) return LAT_W'(MAX_LAT);
        return lat;
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-to-scoreboard and scoreboard-to-Execute signal bundle.
interface issue_scoreboard_if;
    import issue_pkg::*;

    logic              id_is_valid;
    logic [REG_AW-1:0] id_is_addra;
    logic [REG_AW-1:0] id_is_addrb;
    logic [1:0]        id_is_numop;
    logic [REG_AW-1:0] id_is_regdest;
    logic              id_is_writereg;
    logic [FU_W-1:0]   id_is_unidadefuncional;
    logic [LAT_W-1:0]  id_is_latency;

    logic              is_if_stall;
    logic              is_ex_valid;
    logic [REG_AW-1:0] is_ex_regdest;
    logic              is_ex_writereg;
    logic [FU_W-1:0]   is_ex_unidadefuncional;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_regdest;
    logic [NUM_REGS-1:0] busy_regs;

    modport master (
        output id_is_valid, id_is_addra, id_is_addrb, id_is_numop,
               id_is_regdest, id_is_writereg, id_is_unidadefuncional, id_is_latency,
        input  is_if_stall, is_ex_valid, is_ex_regdest, is_ex_writereg,
               is_ex_unidadefuncional, wb_valid, wb_regdest, busy_regs
    );

    modport slave (
        input  id_is_valid, id_is_addra, id_is_addrb, id_is_numop,
               id_is_regdest, id_is_writereg, id_is_unidadefuncional, id_is_latency,
        output is_if_stall, is_ex_valid, is_ex_regdest, is_ex_writereg,
               is_ex_unidadefuncional, wb_valid, wb_regdest, busy_regs
    );

endinterface

// File: rtl/issue_scoreboard_wb_slot_queue.sv
// Writeback reservation queue: slot k holds the instruction completing k cycles from now.
module wb_slot_queue
    import issue_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ins_en,
    input  logic [LAT_W-1:0] i_ins_idx,
    input  wb_entry_t        i_ins_entry,
    input  logic [LAT_W-1:0] i_query_lat,
    output logic             o_query_occ,
    output wb_entry_t        o_slot0
);

    wb_entry_t r_slot [MAX_LAT];
    wb_entry_t w_next [MAX_LAT];

    // A request for latency L collides with whatever sits in slot L now, since both
    // land in slot L-1 after this edge; slot MAX_LAT does not exist, so it is always free.
    always_comb begin
        // NOTE: default first so no path through the loop leaves the output unassigned (no latch).
        o_query_occ = 1'b0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (LAT_W'(i) == i_query_lat) o_query_occ = r_slot[i].valid;
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_LAT - 1; i++) w_next[i] = r_slot[i + 1];
        w_next[MAX_LAT - 1] = '0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (i_ins_en && LAT_W'(i) == i_ins_idx) w_next[i] = i_ins_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the slot array is reset, unlike a datapath RAM, so that in-flight work is dropped.
            for (int i = 0; i < MAX_LAT; i++) r_slot[i] <= '0;
        end else begin
            // NOTE: non-blocking so every slot shifts from the pre-edge values.
            for (int i = 0; i < MAX_LAT; i++) r_slot[i] <= w_next[i];
        end
    end

    assign o_slot0 = r_slot[0];

endmodule

// File: rtl/issue_scoreboard.sv
// In-order single-issue scoreboard: RAW/WAW, functional-unit and writeback-port hazards
// decide each cycle whether the Decode instruction moves to Execute.
module issue_scoreboard
    import issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    issue_scoreboard_if.slave sb
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [LAT_W-1:0]    r_fu_cnt [NUM_FU];

    logic                r_ex_valid;
    logic [REG_AW-1:0]   r_ex_regdest;
    logic                r_ex_writereg;
    logic [FU_W-1:0]     r_ex_fu;

    wb_entry_t           w_slot0;
    wb_entry_t           w_ins_entry;
    logic [LAT_W-1:0]    w_lat;
    logic                w_tracked;
    logic                w_retiring;
    logic                w_a_busy;
    logic                w_b_busy;
    logic                w_d_busy;
    logic                w_raw;
    logic                w_waw;
    logic                w_fu_hz;
    logic                w_wb_hz;
    logic                w_hazard;
    logic                w_issue;

    assign w_lat      = eff_latency(sb.id_is_latency);
    assign w_tracked  = sb.id_is_writereg && (sb.id_is_regdest != '0);
    assign w_retiring = w_slot0.valid && w_slot0.writereg && (w_slot0.regdest != '0);

    // The register retiring this cycle counts as ready: the register file writes through.
    assign w_a_busy = (sb.id_is_addra != '0) && r_pending[sb.id_is_addra]
                      && !(w_retiring && w_slot0.regdest == sb.id_is_addra);
    assign w_b_busy = (sb.id_is_addrb != '0) && r_pending[sb.id_is_addrb]
                      && !(w_retiring && w_slot0.regdest == sb.id_is_addrb);
    assign w_d_busy = r_pending[sb.id_is_regdest]
                      && !(w_retiring && w_slot0.regdest == sb.id_is_regdest);

    assign w_raw = ((sb.id_is_numop != 2'd0) && w_a_busy) || (sb.id_is_numop[1] && w_b_busy);
    assign w_waw = w_tracked && w_d_busy;

    // A unit is free again in its last busy cycle, hence the "> 1" test.
    always_comb begin
        w_fu_hz = 1'b0;
        for (int u = 0; u < NUM_FU; u++) begin
            if (FU_W'(u) == sb.id_is_unidadefuncional && r_fu_cnt[u] > LAT_W'(1)) w_fu_hz = 1'b1;
        end
    end

    assign w_hazard = w_raw || w_waw || w_fu_hz || w_wb_hz;
    assign w_issue  = sb.id_is_valid && !w_hazard;

    assign w_ins_entry = '{valid: 1'b1, regdest: sb.id_is_regdest, writereg: sb.id_is_writereg};

    wb_slot_queue u_wb_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ins_en    (w_issue),
        .i_ins_idx   (w_lat - LAT_W'(1)),
        .i_ins_entry (w_ins_entry),
        .i_query_lat (w_lat),
        .o_query_occ (w_wb_hz),
        .o_slot0     (w_slot0)
    );

    // Retire clears first, issue sets second: a same-cycle re-issue to the retiring dest stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_slot0.valid && w_slot0.writereg) w_pending_nxt[w_slot0.regdest] = 1'b0;
        if (w_issue && w_tracked) w_pending_nxt[sb.id_is_regdest] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            for (int u = 0; u < NUM_FU; u++) r_fu_cnt[u] <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            for (int u = 0; u < NUM_FU; u++) begin
                if (w_issue && FU_W'(u) == sb.id_is_unidadefuncional) r_fu_cnt[u] <= w_lat;
                else if (r_fu_cnt[u] != '0) r_fu_cnt[u] <= r_fu_cnt[u] - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_regdest  <= '0;
            r_ex_writereg <= 1'b0;
            r_ex_fu       <= '0;
        end else begin
            r_ex_valid <= w_issue;
            if (w_issue) begin
                r_ex_regdest  <= sb.id_is_regdest;
                r_ex_writereg <= sb.id_is_writereg;
                r_ex_fu       <= sb.id_is_unidadefuncional;
            end
        end
    end

    assign sb.is_if_stall            = sb.id_is_valid && w_hazard;
    assign sb.is_ex_valid            = r_ex_valid;
    assign sb.is_ex_regdest          = r_ex_regdest;
    assign sb.is_ex_writereg         = r_ex_writereg;
    assign sb.is_ex_unidadefuncional = r_ex_fu;
    assign sb.wb_valid               = w_slot0.valid;
    assign sb.wb_regdest             = w_slot0.regdest;
    assign sb.busy_regs              = r_pending;

endmodule
